// File: rtl/ext_ref_pkg.sv
// ext_ref_pkg
// Shared definitions for the external-reference transmitter: sequencer mode
// encodings, sequencer state encodings and default widths.
// No ports.
package ext_ref_pkg;

    localparam int ACCUM_WIDTH_DEFAULT = 12;
    localparam int DWELL_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        MODE_CONST   = 2'd0,
        MODE_FSTEP   = 2'd1,
        MODE_PSTEP   = 2'd2,
        MODE_DROPOUT = 2'd3
    } ref_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BASE    = 3'd1,
        ST_TEST    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_DONE    = 3'd4
    } seq_state_e;

endpackage

// File: rtl/ref_step_sequencer.sv
// ref_step_sequencer
// One-shot test sequencer for the reference NCO. Walks IDLE -> BASE -> TEST
// -> RECOVER -> DONE, each middle segment lasting the latched dwell, and tells
// the accumulator which tuning word to use, whether to inject a phase step and
// whether the reference output must be held low.
// Ports:
//   clk_i, reset_i   clock and synchronous active-high reset
//   enable_i         0 freezes state and dwell counter
//   k_val_i          live base tuning word (used directly in IDLE)
//   mode_i, step_i   test mode and its tuning delta / phase offset
//   dwell_i          cycles per segment, 0 behaves as 1
//   start_i          start request, honoured only in IDLE with enable_i high
//   busy_o, done_o   sequence in progress / one-cycle completion pulse
//   k_eff_o          tuning word for this cycle
//   phase_inject_o   extra phase to add this cycle
//   force_low_o      hold the reference output low this cycle
module ref_step_sequencer
    import ext_ref_pkg::*;
#(
    parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEFAULT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [ACCUM_WIDTH-1:0] k_val_i,
    input  logic [1:0]             mode_i,
    input  logic [ACCUM_WIDTH-1:0] step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ACCUM_WIDTH-1:0] k_eff_o,
    output logic [ACCUM_WIDTH-1:0] phase_inject_o,
    output logic                   force_low_o
);

    seq_state_e             state_q, state_d;
    logic [DWELL_WIDTH-1:0] dwellCnt_q, dwellCnt_d;
    logic [DWELL_WIDTH-1:0] dwellLat_q, dwellLat_d;
    logic [ACCUM_WIDTH-1:0] kLat_q, kLat_d;
    logic [ACCUM_WIDTH-1:0] stepLat_q, stepLat_d;
    ref_mode_e              modeLat_q, modeLat_d;
    logic [DWELL_WIDTH-1:0] segLast;
    logic                   segEnd;

    // A zero dwell behaves as a one-cycle segment, so the last count index is 0.
    assign segLast = (dwellLat_q == '0) ? '0 : dwellLat_q - DWELL_WIDTH'(1);
    assign segEnd  = (dwellCnt_q == segLast);

    // Next-state, segment counting and per-mode control outputs. Everything
    // holds while enable_i is low; DONE waits for enable before pulsing.
    always_comb begin
        state_d        = state_q;
        dwellCnt_d     = dwellCnt_q;
        dwellLat_d     = dwellLat_q;
        kLat_d         = kLat_q;
        stepLat_d      = stepLat_q;
        modeLat_d      = modeLat_q;
        k_eff_o        = kLat_q;
        phase_inject_o = '0;
        force_low_o    = 1'b0;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                k_eff_o = k_val_i;
                if (enable_i && start_i) begin
                    kLat_d     = k_val_i;
                    stepLat_d  = step_i;
                    modeLat_d  = ref_mode_e'(mode_i);
                    dwellLat_d = dwell_i;
                    dwellCnt_d = '0;
                    state_d    = ST_BASE;
                end
            end
            ST_BASE, ST_TEST, ST_RECOVER: begin
                busy_o = 1'b1;
                if (state_q == ST_TEST) begin
                    case (modeLat_q)
                        MODE_FSTEP:   k_eff_o = kLat_q + stepLat_q;
                        MODE_PSTEP:   if (dwellCnt_q == '0) phase_inject_o = stepLat_q;
                        MODE_DROPOUT: force_low_o = 1'b1;
                        default:      k_eff_o = kLat_q;
                    endcase
                end
                if (enable_i) begin
                    if (segEnd) begin
                        dwellCnt_d = '0;
                        case (state_q)
                            ST_BASE: state_d = ST_TEST;
                            ST_TEST: state_d = ST_RECOVER;
                            default: state_d = ST_DONE;
                        endcase
                    end else begin
                        dwellCnt_d = dwellCnt_q + DWELL_WIDTH'(1);
                    end
                end
            end
            ST_DONE: begin
                done_o = enable_i;
                if (enable_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, dwell counter and start-time latches.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            dwellCnt_q <= '0;
            dwellLat_q <= '0;
            kLat_q     <= '0;
            stepLat_q  <= '0;
            modeLat_q  <= MODE_CONST;
        end else begin
            state_q    <= state_d;
            dwellCnt_q <= dwellCnt_d;
            dwellLat_q <= dwellLat_d;
            kLat_q     <= kLat_d;
            stepLat_q  <= stepLat_d;
            modeLat_q  <= modeLat_d;
        end
    end

endmodule

// File: rtl/ext_ref_source.sv
// ext_ref_source
// Programmable external-reference transmitter: a phase-accumulator NCO whose
// MSB drives the reference pin, plus a one-shot sequencer that applies a
// frequency step, phase step or dropout for far-end lock testing.
// Ports:
//   fpga_clk_i, reset_i  fabric clock and synchronous active-high reset
//   enable_i             0 freezes accumulator, sequencer and outputs
//   k_val_i              base tuning word, f_out = f_clk*k/2^ACCUM_WIDTH
//   mode_i, step_i       test mode and its delta / phase offset
//   dwell_i              cycles per sequencer segment
//   start_i              start pulse, accepted only when idle
//   busy_o, done_o       sequence running / completion pulse
//   ref_clk_o, edge_o    registered reference and its rising-edge pulse
//   phase_o              current accumulator value
module ext_ref_source
    import ext_ref_pkg::*;
#(
    parameter int ACCUM_WIDTH = ACCUM_WIDTH_DEFAULT,
    parameter int DWELL_WIDTH = DWELL_WIDTH_DEFAULT
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    input  logic [ACCUM_WIDTH-1:0] k_val_i,
    input  logic [1:0]             mode_i,
    input  logic [ACCUM_WIDTH-1:0] step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   ref_clk_o,
    output logic                   edge_o,
    output logic [ACCUM_WIDTH-1:0] phase_o
);

    logic [ACCUM_WIDTH-1:0] acc_q, acc_d;
    logic                   refClk_q, refClk_d;
    logic                   edge_q, edge_d;
    logic [ACCUM_WIDTH-1:0] kEff;
    logic [ACCUM_WIDTH-1:0] phaseInject;
    logic                   forceLow;

    ref_step_sequencer #(
        .ACCUM_WIDTH (ACCUM_WIDTH),
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_seq (
        .clk_i          (fpga_clk_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .k_val_i        (k_val_i),
        .mode_i         (mode_i),
        .step_i         (step_i),
        .dwell_i        (dwell_i),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .k_eff_o        (kEff),
        .phase_inject_o (phaseInject),
        .force_low_o    (forceLow)
    );

    // The reference follows the accumulator MSB one cycle late. During a
    // dropout it is forced low while the accumulator keeps running, so phase
    // stays continuous when the dropout ends. Rising edges are detected on the
    // value being registered, so edge_o lines up with ref_clk_o going high.
    always_comb begin
        acc_d    = acc_q;
        refClk_d = refClk_q;
        edge_d   = 1'b0;
        if (enable_i) begin
            refClk_d = forceLow ? 1'b0 : acc_q[ACCUM_WIDTH-1];
            edge_d   = refClk_d & ~refClk_q;
            acc_d    = acc_q + kEff + phaseInject;
        end
    end

    // Accumulator and output registers.
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            acc_q    <= '0;
            refClk_q <= 1'b0;
            edge_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            refClk_q <= refClk_d;
            edge_q   <= edge_d;
        end
    end

    assign phase_o   = acc_q;
    assign ref_clk_o = refClk_q;
    assign edge_o    = edge_q;

endmodule

// File: tb/tb_ext_ref_source.sv
module tb_ext_ref_source;

    logic        clock = 1'b0;
    logic        reset, enable, start;
    logic [11:0] kVal, stepVal;
    logic [1:0]  mode;
    logic [15:0] dwell;
    logic        busy, done, refClk, edgeO;
    logic [11:0] phase;

    int checks = 0;
    int errors = 0;

    ext_ref_source #(.ACCUM_WIDTH(12), .DWELL_WIDTH(16)) dut (
        .fpga_clk_i (clock),
        .reset_i    (reset),
        .enable_i   (enable),
        .k_val_i    (kVal),
        .mode_i     (mode),
        .step_i     (stepVal),
        .dwell_i    (dwell),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .ref_clk_o  (refClk),
        .edge_o     (edgeO),
        .phase_o    (phase)
    );

    always #5 clock = ~clock;

    // Reference model: the sequence is tracked as a count of enabled cycles
    // since the start was accepted; segment membership comes from dividing
    // that position by the dwell.
    logic [11:0] mAcc, mK, mStep, kEffM, injM;
    logic [1:0]  mMode;
    logic        mRef, mEdge, newRef, fLow, inTest;
    bit          mRun = 0;
    bit          mValid = 0;
    int          mPos = 0;
    int          mD = 1;

    always @(posedge clock) begin
        if (reset) begin
            mAcc = '0; mRef = 0; mEdge = 0; mRun = 0; mPos = 0;
        end else if (enable) begin
            inTest = mRun && (mPos >= mD) && (mPos < 2 * mD);
            kEffM  = mRun ? mK : kVal;
            injM   = '0;
            fLow   = 0;
            if (inTest && mMode == 2'd1) kEffM = mK + mStep;
            if (mRun && mPos == mD && mMode == 2'd2) injM = mStep;
            if (inTest && mMode == 2'd3) fLow = 1;
            newRef = fLow ? 1'b0 : mAcc[11];
            mEdge  = newRef & ~mRef;
            mRef   = newRef;
            mAcc   = mAcc + kEffM + injM;
            if (!mRun) begin
                if (start) begin
                    mK = kVal; mStep = stepVal; mMode = mode;
                    mD = (dwell == 16'd0) ? 1 : int'(dwell);
                    mRun = 1; mPos = 0;
                end
            end else if (mPos == 3 * mD) begin
                mRun = 0;
            end else begin
                mPos++;
            end
        end else begin
            mEdge = 0;
        end
        mValid = 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (mValid) begin
            checkOutput("phase_o", 32'(phase), 32'(mAcc));
            checkOutput("ref_clk_o", 32'(refClk), 32'(mRef));
            checkOutput("edge_o", 32'(edgeO), 32'(mEdge));
            checkOutput("busy_o", 32'(busy), 32'(mRun && mPos < 3 * mD));
            checkOutput("done_o", 32'(done), 32'(mRun && mPos == 3 * mD && enable));
        end
    end

    initial begin
        repeat (90000) @(posedge clock);
        $display("[TB] FAIL watchdog cycle budget exceeded");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic st, input logic [1:0] md, input logic [11:0] k,
                                 input logic [11:0] stp, input logic [15:0] dw, input logic en);
        start = st; mode = md; kVal = k; stepVal = stp; dwell = dw; enable = en;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [11:0] ph [0:199];
    logic        rf [0:199];
    logic [11:0] tmp, ph0, prevPhase;
    int firstRise, edges, lastEdge, badGap, busyCnt, doneCnt, bad, phBad, firstAfter, predicted;
    int segEdges [0:2];

    initial begin
        reset = 1;
        applyStimulus(0, 2'd0, 12'd90, 12'd0, 16'd0, 1);
        repeat (3) tick();
        reset = 0;
        checkOutput("reset_phase", 32'(phase), 0);
        checkOutput("reset_ref", 32'(refClk), 0);
        checkOutput("reset_edge", 32'(edgeO), 0);
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_done", 32'(done), 0);

        $display("[TB] idle rate");
        firstRise = 0; edges = 0; lastEdge = 0; badGap = 0;
        for (int n = 1; n <= 40960; n++) begin
            tick();
            if (n == 1) checkOutput("idle_phase_n1", 32'(phase), 90);
            if (n == 5) checkOutput("idle_phase_n5", 32'(phase), 450);
            if (refClk && firstRise == 0) firstRise = n;
            if (edgeO) begin
                if (lastEdge != 0 && (n - lastEdge < 45 || n - lastEdge > 46)) badGap++;
                lastEdge = n;
                edges++;
            end
        end
        checkOutput("first_rise_cycle", 32'(firstRise), 24);
        checkOutput("idle_edge_count", 32'(edges), 900);
        checkOutput("idle_bad_spacing", 32'(badGap), 0);

        $display("[TB] frequency step");
        applyStimulus(1, 2'd1, 12'd90, 12'd10, 16'd4096, 1);
        tick();
        start = 0;
        busyCnt = 0; doneCnt = 0;
        for (int s = 0; s < 3; s++) segEdges[s] = 0;
        for (int p = 0; p < 12300; p++) begin
            if (busy) busyCnt++;
            if (done) doneCnt++;
            if (edgeO && p < 12288) segEdges[p / 4096]++;
            tick();
        end
        checkRange("fstep_base_edges", segEdges[0], 89, 91);
        checkRange("fstep_test_edges", segEdges[1], 99, 101);
        checkRange("fstep_recover_edges", segEdges[2], 89, 91);
        checkOutput("fstep_busy_cycles", 32'(busyCnt), 12288);
        checkOutput("fstep_done_pulses", 32'(doneCnt), 1);

        $display("[TB] phase step");
        applyStimulus(1, 2'd2, 12'd90, 12'd2048, 16'd64, 1);
        tick();
        start = 0;
        for (int p = 0; p < 200; p++) begin
            ph[p] = phase;
            rf[p] = refClk;
            tick();
        end
        tmp = ph[65] - ph[64];
        checkOutput("pstep_jump", 32'(tmp), 2138);
        tmp = ph[64] - ph[63];
        checkOutput("pstep_base_step", 32'(tmp), 90);
        bad = 0;
        for (int p = 1; p <= 190; p++) begin
            tmp = ph[0] + 12'(90 * (p - 1));
            if (p <= 65 && rf[p] !== tmp[11]) bad++;
            if (p >= 66 && rf[p] !== ~tmp[11]) bad++;
        end
        checkOutput("pstep_ref_inversion", 32'(bad), 0);

        $display("[TB] dropout");
        applyStimulus(1, 2'd3, 12'd90, 12'd0, 16'd1000, 1);
        tick();
        start = 0;
        bad = 0; phBad = 0; firstAfter = 0; ph0 = phase; prevPhase = phase;
        for (int p = 0; p < 3010; p++) begin
            if (p >= 1001 && p <= 2000) begin
                if (refClk || edgeO) bad++;
                tmp = phase - prevPhase;
                if (tmp != 12'd90) phBad++;
            end
            if (p > 2000 && edgeO && firstAfter == 0) firstAfter = p;
            prevPhase = phase;
            tick();
        end
        predicted = 0;
        for (int q = 2001; q < 3010; q++) begin
            tmp = ph0 + 12'(90 * (q - 1));
            if (predicted == 0 && tmp[11]) predicted = q;
        end
        checkOutput("dropout_ref_low", 32'(bad), 0);
        checkOutput("dropout_phase_steps", 32'(phBad), 0);
        checkOutput("dropout_first_edge", 32'(firstAfter), 32'(predicted));

        $display("[TB] boundaries");
        applyStimulus(1, 2'd0, 12'd90, 12'd0, 16'd8, 1);
        tick();
        start = 0;
        busyCnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (busy) busyCnt++;
            if (i == 10) applyStimulus(1, 2'd1, 12'd200, 12'd5, 16'd100, 1);
            if (i == 11) applyStimulus(0, 2'd0, 12'd90, 12'd0, 16'd8, 1);
            tick();
        end
        checkOutput("restart_ignored_busy", 32'(busyCnt), 24);

        applyStimulus(1, 2'd0, 12'd90, 12'd0, 16'd0, 1);
        tick();
        start = 0;
        busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy) busyCnt++;
            if (done) doneCnt++;
            tick();
        end
        checkOutput("dwell0_busy", 32'(busyCnt), 3);
        checkOutput("dwell0_done", 32'(doneCnt), 1);

        applyStimulus(1, 2'd1, 12'd90, 12'd10, 16'd10, 1);
        tick();
        start = 0;
        repeat (12) tick();
        reset = 1;
        tick();
        checkOutput("midreset_busy", 32'(busy), 0);
        checkOutput("midreset_phase", 32'(phase), 0);
        checkOutput("midreset_ref", 32'(refClk), 0);
        reset = 0;
        tick();
        checkOutput("after_reset_phase", 32'(phase), 90);

        applyStimulus(1, 2'd0, 12'd90, 12'd0, 16'd20, 1);
        tick();
        start = 0;
        busyCnt = 0; doneCnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy) busyCnt++;
            if (done) doneCnt++;
            if (i == 25) enable = 0;
            if (i == 75) enable = 1;
            tick();
        end
        checkOutput("enable_stall_busy", 32'(busyCnt), 110);
        checkOutput("enable_stall_done", 32'(doneCnt), 1);

        $display("[TB] randomized sequences");
        for (int it = 0; it < 40; it++) begin
            int dw;
            dw = int'($urandom_range(0, 12));
            applyStimulus(1, 2'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), 16'(dw), 1);
            for (int c = 0; c < 3 * (dw + 1) + 15; c++) begin
                tick();
                start  = ($urandom_range(0, 7) == 0);
                enable = ($urandom_range(0, 9) != 0);
                if ($urandom_range(0, 4) == 0) kVal = 12'($urandom);
                if ($urandom_range(0, 4) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 4) == 0) stepVal = 12'($urandom);
            end
        end
        enable = 1;
        start = 0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
